// File: rtl/dvi_in_align_ctrl.sv
// rtl/dvi_in_align_ctrl.sv - per-lane leaky-bucket tap/bitslip aligner for DVI input lanes
module dvi_in_align_ctrl #(
  parameter int               CHANNELS    = 3,
  parameter int               DELAY_W     = 5,
  parameter int               ERR_W       = 28,
  parameter logic [ERR_W-1:0] ERR_INC     = 'h200000,
  parameter logic [ERR_W-1:0] ERR_DEC     = 'h1,
  parameter int               COOLDOWN_W  = 10,
  parameter logic [ERR_W-1:0] LOCK_THRESH = 'h0100000
) (
  input  logic                         pclk1x,
  input  logic                         rst_ps,
  input  logic [CHANNELS-1:0]          valid,
  input  logic [3:0]                   increment,
  input  logic                         manual_en,
  input  logic [CHANNELS*DELAY_W-1:0]  manual_delay,
  output logic [CHANNELS*DELAY_W-1:0]  delay,
  output logic [CHANNELS-1:0]          bitslip,
  output logic [CHANNELS*ERR_W-1:0]    error_counter,
  output logic [CHANNELS-1:0]          locked,
  output logic                         all_locked,
  output logic [CHANNELS*8-1:0]        relock_count
);

  logic [CHANNELS-1:0] locked_d;
  logic                all_locked_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    logic [COOLDOWN_W-1:0] cd_q, cd_d;
    logic [ERR_W-1:0]      err_q, err_d, err_n;
    logic [ERR_W:0]        err_sum;
    logic [DELAY_W-1:0]    dly_q, dly_d;
    logic                  slip_q, slip_d;
    logic                  lock_q, lock_d;
    logic [7:0]            rlc_q, rlc_d;
    logic                  trigger;

    // One extra bit on the sum lets the integrator clamp instead of wrapping.
    always_comb begin
      err_sum = {1'b0, err_q} + {1'b0, ERR_INC};
      if (!valid[g]) begin
        err_n = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
      end else if (err_q >= ERR_DEC) begin
        err_n = err_q - ERR_DEC;
      end else begin
        err_n = '0;
      end
    end

    assign trigger = !manual_en && (cd_q == '0) && !valid[g] &&
                     (err_q[ERR_W-1 -: 4] == 4'hF);

    always_comb begin
      cd_d   = cd_q;
      err_d  = err_q;
      dly_d  = dly_q;
      slip_d = 1'b0;
      lock_d = lock_q;
      rlc_d  = rlc_q;
      if (manual_en) begin
        dly_d  = manual_delay[g*DELAY_W +: DELAY_W];
        cd_d   = '0;
        err_d  = err_n;
        lock_d = (err_n < LOCK_THRESH);
      end else if (cd_q != '0) begin
        cd_d = cd_q - COOLDOWN_W'(1);
      end else if (trigger) begin
        dly_d  = dly_q + DELAY_W'(increment);
        slip_d = &dly_q;
        cd_d   = '1;
        // Restart the bucket at a quarter so the next retune needs a real error burst.
        err_d  = {4'b0100, err_n[ERR_W-5:0]};
        lock_d = 1'b0;
      end else begin
        err_d  = err_n;
        lock_d = (err_n < LOCK_THRESH);
      end
      if (lock_q && !lock_d && (rlc_q != 8'hFF)) begin
        rlc_d = rlc_q + 8'd1;
      end
    end

    always_ff @(posedge pclk1x or posedge rst_ps) begin
      if (rst_ps) begin
        cd_q   <= '0;
        err_q  <= '0;
        dly_q  <= '0;
        slip_q <= 1'b0;
        lock_q <= 1'b0;
        rlc_q  <= '0;
      end else begin
        cd_q   <= cd_d;
        err_q  <= err_d;
        dly_q  <= dly_d;
        slip_q <= slip_d;
        lock_q <= lock_d;
        rlc_q  <= rlc_d;
      end
    end

    assign locked_d[g]                       = lock_d;
    assign delay[g*DELAY_W +: DELAY_W]       = dly_q;
    assign bitslip[g]                        = slip_q;
    assign error_counter[g*ERR_W +: ERR_W]   = err_q;
    assign locked[g]                         = lock_q;
    assign relock_count[g*8 +: 8]            = rlc_q;
  end

  // Built from next-state lock bits so it updates on the same edge as locked.
  always_ff @(posedge pclk1x or posedge rst_ps) begin
    if (rst_ps) begin
      all_locked_q <= 1'b0;
    end else begin
      all_locked_q <= &locked_d;
    end
  end

  assign all_locked = all_locked_q;

endmodule
